// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - streams LUT configuration words MSB-first onto a daisy-chained serial config path
module lut_config_loader #(
  parameter int WIDTH    = 16,
  parameter int NUM_LUTS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             config_in,
  output logic             config_en,
  output logic             busy,
  output logic             done
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WCW = $clog2(NUM_LUTS + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WIDTH - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_LUTS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [BCW-1:0]   bit_cnt;
  logic [WCW-1:0]   word_cnt;
  logic [WIDTH-1:0] shreg;
  logic             final_bit;
  logic             last_word;
  logic             transfer;

  assign final_bit  = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign last_word  = (word_cnt == LAST_WORD);
  assign word_ready = (state == WAIT_WORD) || (final_bit && !last_word);
  assign transfer   = word_valid && word_ready && !abort;
  assign busy       = (state == WAIT_WORD) || (state == SHIFT);
  assign done       = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = WAIT_WORD;
      WAIT_WORD: begin
        if (abort)         state_next = IDLE;
        else if (transfer) state_next = SHIFT;
      end
      SHIFT: begin
        if (abort) state_next = IDLE;
        else if (final_bit) begin
          if (transfer)       state_next = SHIFT;
          else if (last_word) state_next = DONE;
          else                state_next = WAIT_WORD;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // config_in/config_en are loaded on the transfer edge so the MSB appears in the first SHIFT cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      word_cnt  <= '0;
      shreg     <= '0;
      config_in <= 1'b0;
      config_en <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end
      if (abort && busy) begin
        shreg     <= '0;
        config_in <= 1'b0;
        config_en <= 1'b0;
        bit_cnt   <= '0;
      end else if (transfer) begin
        shreg     <= word_in << 1;
        config_in <= word_in[WIDTH-1];
        config_en <= 1'b1;
        bit_cnt   <= '0;
        if (state == SHIFT) word_cnt <= word_cnt + WCW'(1);
      end else if (state == SHIFT) begin
        if (final_bit) begin
          shreg     <= '0;
          config_in <= 1'b0;
          config_en <= 1'b0;
          bit_cnt   <= '0;
          if (!last_word) word_cnt <= word_cnt + WCW'(1);
        end else begin
          shreg     <= shreg << 1;
          config_in <= shreg[WIDTH-1];
          config_en <= 1'b1;
          bit_cnt   <= bit_cnt + BCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// tb/tb_lut_config_loader.sv - table-driven bench for lut_config_loader with WIDTH=16, NUM_LUTS=2
module tb_lut_config_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        config_in;
  logic        config_en;
  logic        busy;
  logic        done;

  lut_config_loader #(.WIDTH(16), .NUM_LUTS(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .config_in  (config_in),
    .config_en  (config_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // expected outputs packed as {config_in, config_en, word_ready, busy, done}
  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_WAIT = 5'b00110;
  localparam logic [4:0] E_DONE = 5'b00001;

  typedef struct {
    logic        st;
    logic        ab;
    logic        vl;
    logic [15:0] w;
    logic [4:0]  exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   en_count = 0;

  task automatic check(input logic [4:0] exp, input string tag, input int idx);
    logic [4:0] act;
    act = {config_in, config_en, word_ready, busy, done};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: in/en/rdy/busy/done got %b expected %b", tag, idx, act, exp);
    end
  endtask

  task automatic push(input logic st, input logic ab, input logic vl,
                      input logic [15:0] w, input logic [4:0] exp, input string tag);
    vec_t v;
    v.st = st; v.ab = ab; v.vl = vl; v.w = w; v.exp = exp; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic push_shift(input logic [15:0] w, input logic more, input logic vl,
                            input logic [15:0] nw, input int nbits, input int start_at,
                            input int abort_at, input string tag);
    for (int k = 0; k < nbits; k++)
      push(k == start_at, k == abort_at, vl, nw,
           {w[15-k], 1'b1, (k == 15) && more, 1'b1, 1'b0}, tag);
  endtask

  task automatic push_session(input logic [15:0] w0, input logic [15:0] w1, input string tag);
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_IDLE, {tag, "_start"});
    push(1'b0, 1'b0, 1'b1, w0, E_WAIT, {tag, "_wait"});
    push_shift(w0, 1'b1, 1'b1, w1, 16, -1, -1, {tag, "_w0"});
    push_shift(w1, 1'b0, 1'b0, 16'h0000, 16, -1, -1, {tag, "_w1"});
    push(1'b0, 1'b0, 1'b0, 16'h0000, E_DONE, {tag, "_done"});
    push(1'b0, 1'b0, 1'b0, 16'h0000, E_IDLE, {tag, "_idle"});
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(negedge clock);
      start      = vecs[i].st;
      abort      = vecs[i].ab;
      word_valid = vecs[i].vl;
      word_in    = vecs[i].w;
      #1;
      check(vecs[i].exp, vecs[i].tag, i);
      if (vecs[i].exp == E_DONE) begin
        n_vec++;
        if (en_count != 32) begin
          n_bad++;
          $display("FAIL %s_en_count: got %0d expected 32", vecs[i].tag, en_count);
        end
      end
      if (vecs[i].st && vecs[i].exp == E_IDLE) en_count = 0;
      if (config_en) en_count++;
    end
    vecs.delete();
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; start = 1'b0; abort = 1'b0;
    word_valid = 1'b0; word_in = 16'h0000;
    #7;
    check(E_IDLE, "reset_held", 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check(E_IDLE, "reset_release", 0);

    // gapless two-word session
    push_session(16'hA5C3, 16'h0F0F, "gap");

    // second word arrives five cycles after the first finishes shifting
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_IDLE, "stall_start");
    push(1'b0, 1'b0, 1'b1, 16'h8001, E_WAIT, "stall_wait");
    push_shift(16'h8001, 1'b1, 1'b0, 16'h0000, 16, -1, -1, "stall_w0");
    for (int n = 0; n < 4; n++) push(1'b0, 1'b0, 1'b0, 16'h0000, E_WAIT, "stall_gap");
    push(1'b0, 1'b0, 1'b1, 16'hFFFF, E_WAIT, "stall_gap_valid");
    push_shift(16'hFFFF, 1'b0, 1'b0, 16'h0000, 16, -1, -1, "stall_w1");
    push(1'b0, 1'b0, 1'b0, 16'h0000, E_DONE, "stall_done");
    push(1'b0, 1'b0, 1'b0, 16'h0000, E_IDLE, "stall_idle");

    // word_valid in IDLE and start during SHIFT/DONE are ignored
    for (int n = 0; n < 3; n++) push(1'b0, 1'b0, 1'b1, 16'h1234, E_IDLE, "ign_idle_valid");
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_IDLE, "ign_start");
    push(1'b0, 1'b0, 1'b1, 16'h3C3C, E_WAIT, "ign_wait");
    push_shift(16'h3C3C, 1'b1, 1'b1, 16'hC3C3, 16, 5, -1, "ign_w0");
    push_shift(16'hC3C3, 1'b0, 1'b0, 16'h0000, 16, 3, -1, "ign_w1");
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_DONE, "ign_done_start");
    push(1'b0, 1'b0, 1'b0, 16'h0000, E_IDLE, "ign_idle");

    // abort while bit 7 of word 0 is on the wire, then a full recovery session
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_IDLE, "abt_start");
    push(1'b0, 1'b0, 1'b1, 16'hA5C3, E_WAIT, "abt_wait");
    push_shift(16'hA5C3, 1'b1, 1'b0, 16'h0000, 9, -1, 8, "abt_w0");
    for (int n = 0; n < 3; n++) push(1'b0, 1'b0, 1'b1, 16'h7777, E_IDLE, "abt_after");
    push_session(16'h1234, 16'hFEDC, "abt_rec");

    // abort beats a simultaneous transfer in WAIT_WORD and in the final SHIFT cycle
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_IDLE, "pri_start");
    push(1'b0, 1'b1, 1'b1, 16'h5555, E_WAIT, "pri_wait_abort");
    push(1'b0, 1'b0, 1'b1, 16'h5555, E_IDLE, "pri_wait_after");
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_IDLE, "pri_start2");
    push(1'b0, 1'b0, 1'b1, 16'h00FF, E_WAIT, "pri_wait2");
    push_shift(16'h00FF, 1'b1, 1'b1, 16'hAAAA, 16, -1, 15, "pri_w0");
    push(1'b0, 1'b0, 1'b1, 16'hAAAA, E_IDLE, "pri_shift_after");
    push(1'b0, 1'b0, 1'b0, 16'h0000, E_IDLE, "pri_idle");
    run_table();

    // asynchronous reset while bit counter is 10
    push(1'b1, 1'b0, 1'b0, 16'h0000, E_IDLE, "rst_start");
    push(1'b0, 1'b0, 1'b1, 16'h9999, E_WAIT, "rst_wait");
    push_shift(16'h9999, 1'b1, 1'b0, 16'h0000, 11, -1, -1, "rst_w0");
    run_table();
    reset = 1'b1;
    #1;
    check(E_IDLE, "rst_async", 0);
    @(negedge clock);
    #1;
    check(E_IDLE, "rst_held", 0);
    reset = 1'b0;
    word_valid = 1'b1;
    for (int n = 0; n < 3; n++) push(1'b0, 1'b0, 1'b1, 16'h4321, E_IDLE, "rst_after");
    push_session(16'h6B6B, 16'h0001, "rst_rec");
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_config_loader.md
LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

Interface
REQ-001 Parameter WIDTH, default 16: configuration bits per LUT; equals the downstream LUT's WIDTH.
REQ-002 Parameter NUM_LUTS, default 1: number of LUTs daisy-chained on the serial configuration path; range 1..64.
REQ-003 Port clock  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port start  input  1: one-cycle request to begin a configuration session.
REQ-006 Port abort  input  1: synchronous request to terminate the session.
REQ-007 Port word_in  input  WIDTH: one LUT configuration word.
REQ-008 Port word_valid  input  1: word_in is valid.
REQ-009 Port word_ready  output  1: loader accepts word_in this cycle.
REQ-010 Port config_in  output  1: registered serial configuration bit to the downstream LUT chain.
REQ-011 Port config_en  output  1: registered; high exactly when config_in carries a valid bit and the chain must shift.
REQ-012 Port busy  output  1: high in WAIT_WORD and SHIFT.
REQ-013 Port done  output  1: one-cycle pulse marking completion of a full session.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-015 IDLE: start=1 -> WAIT_WORD, with word counter=0; all other inputs are ignored.
REQ-016 A word transfer SHALL occur on a rising edge where word_valid && word_ready; a transfer loads the shift register and goes to SHIFT with bit counter=0.
REQ-017 word_ready SHALL be 1 in WAIT_WORD, and in the final SHIFT cycle (bit counter=WIDTH-1) when word counter < NUM_LUTS-1; otherwise 0.
REQ-018 SHIFT: for WIDTH consecutive cycles after the transfer, config_en=1 and config_in=word bits WIDTH-1 down to 0 (MSB first).
REQ-019 Word 0 SHALL be shifted first, so it ends up in the LUT farthest from the loader.
REQ-020 End of the final SHIFT cycle, with a transfer in that cycle: stay in SHIFT and start the next word with no idle cycle (gapless).
REQ-021 End of the final SHIFT cycle, more words pending and no transfer: go to WAIT_WORD.
REQ-022 End of the final SHIFT cycle on the last word (word counter=NUM_LUTS-1): go to DONE.
REQ-023 WAIT_WORD: config_en=0 and config_in=0 while word_valid is low; waiting is unbounded.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 The done pulse SHALL appear in the cycle after the last config_en=1 cycle.
REQ-026 abort=1 in WAIT_WORD or SHIFT -> IDLE on the next edge: config_en=0, busy=0, no done pulse, partial shift left incomplete.
REQ-027 abort SHALL take priority over a simultaneous transfer.
REQ-028 start while busy or in DONE SHALL be ignored.
REQ-029 Counter widths: bit counter $clog2(WIDTH); word counter $clog2(NUM_LUTS+1).
REQ-030 Counters SHALL reset to 0 on every session start; no wrap-around occurs within a session.
REQ-031 Exactly WIDTH*NUM_LUTS config_en=1 cycles SHALL occur per completed session.

Reset
REQ-032 On reset=1 the block SHALL go asynchronously to IDLE and clear counters and the shift register.
REQ-033 While reset=1, and after its release, outputs SHALL be: config_in=0, config_en=0, word_ready=0, busy=0, done=0.
REQ-034 Reset mid-session SHALL discard the session; the first post-reset action requires a new start.

Verification
REQ-035 Reset: assert reset asynchronously between edges -> all outputs 0 immediately; only start then resumes activity.
REQ-036 Gapless, NUM_LUTS=2: start, then word_valid held with 16'hA5C3 then 16'h0F0F -> 32 contiguous config_en cycles, config_in=1010010111000011 0000111100001111, done exactly one cycle after the last bit.
REQ-037 Stall, NUM_LUTS=2: second word presented 5 cycles late -> 5 cycles with config_en=0, config_in=0, busy=1, word_ready=1, then shifting resumes; total config_en count=32.
REQ-038 Abort: abort asserted in the cycle carrying bit 7 of word 0 -> next cycle config_en=0, busy=0; done never pulses; a new start runs a full session.
REQ-039 Ignored inputs: word_valid=1 in IDLE -> word_ready=0, no shifting; start pulsed mid-SHIFT -> sequence and counts unchanged.
REQ-040 Reset mid-shift: reset asserted at bit 10 -> config_en drops immediately; after release, no activity until start.
